// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and bit-timing helper.
// Also imported by the on-board start-bit transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int clocksPerBit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin, plus falling-edge detect.
// All flops reset high so that an idle line never looks like an edge.
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rxSync,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rxSync = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50000000,
  parameter int BaudRate       = 115200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frameError,
  output logic                 parityError,
  output logic                 busy
);

  localparam int BIT  = clocksPerBit(ClockFrequency, BaudRate);
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);

  generate
    if (BIT < 4) begin : g_bit_check
      $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
    end
  endgenerate

  logic rx_sync;
  logic fall;

  uart_rx_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .rx     (rx),
    .rxSync (rx_sync),
    .fall   (fall)
  );

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  logic sample;
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Only a genuine high-to-low transition arms the receiver.
        if (fall) begin
          state_d = START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      START: begin
        if (sample) begin
          cnt_d = CW'(BIT - 1);
          if (!rx_sync) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d = CW'(BIT - 1);
          sh_d  = {rx_sync, sh_q[DATA_BITS-1:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          cnt_d   = CW'(BIT - 1);
          pbad_d  = (rx_sync != ^sh_q);
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (sample) begin
          cnt_d   = CW'(BIT - 1);
          state_d = IDLE;
          // A low stop bit outranks a parity mismatch.
          if (!rx_sync) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (pbad_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            valid_d = 1'b1;
            data_d  = sh_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frameError = ferr_q;
  assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parityError = perr_q;
`else
  assign parityError = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at 16 clocks per bit.
// Expected strobes come from frame contents and line timing alone.
module tb_uart_rx;

  localparam int BIT  = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 3 + HALF + (NB - 1) * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       valid, frameError, parityError, busy;

  uart_rx #(.ClockFrequency(16), .BaudRate(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frameError  (frameError),
    .parityError (parityError),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         t;
    logic [7:0] d;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  always @(negedge clock) begin
    if (valid)       obs_q.push_back('{1, cyc, data});
    if (frameError)  obs_q.push_back('{2, cyc, 8'h00});
    if (parityError) obs_q.push_back('{3, cyc, 8'h00});
  end

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] last_good   = 8'h00;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v,
                      input int limit, output int st);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    q.push_back(par_v);
`endif
    q.push_back(stop_v);
    st = cyc;
    for (int c = 0; c < NB * BIT && c < limit; c++) begin
      rx = q[c / BIT];
      step();
    end
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic stop_v, input logic par_v,
                              input int st);
    int k;
    k = 1;
    if (!stop_v) k = 2;
`ifdef UART_RX_PARITY_EN
    else if (par_v != ^b) k = 3;
`endif
    exp_q.push_back('{k, st + LAT, (k == 1) ? b : 8'h00});
    if (k == 1) last_good = b;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    int st;
    send(b, stop_v, par_v, NB * BIT, st);
    expect_frame(b, stop_v, par_v, st);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, " strobes"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s ev%0d time", tag, i), obs_q[i].t, exp_q[i].t);
      if (exp_q[i].kind == 1)
        check($sformatf("%s ev%0d data", tag, i), obs_q[i].d, exp_q[i].d);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data"}, data, 8'h00);
    check({tag, " valid"}, valid, 1'b0);
    check({tag, " frameError"}, frameError, 1'b0);
    check({tag, " parityError"}, parityError, 1'b0);
    check({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    int st;
    int gap;
    logic [7:0] rb;
    logic rs, rp;

    // Reset state
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(20);
    check_reset_outputs("post-reset idle");
    obs_q.delete();

    // Single frame 0x55
    frame(8'h55, 1'b1, ^8'h55);
    idle(20);
    compare_events("f55");
    check("f55 data hold", data, 8'h55);
    check("f55 busy", busy, 1'b0);

    // Back-to-back frames, no idle gap
    frame(8'hA3, 1'b1, ^8'hA3);
    frame(8'h0F, 1'b1, ^8'h0F);
    idle(20);
    if (obs_q.size() >= 2) check("b2b spacing", obs_q[1].t - obs_q[0].t, 160);
    compare_events("b2b");
    check("b2b data", data, 8'h0F);

    // Start-bit glitch: low for 4 cycles only
    st = cyc;
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    while (cyc < st + 3 + HALF - 1) step();
    check("glitch busy before mid", busy, 1'b1);
    step();
    check("glitch busy at mid", busy, 1'b0);
    idle(40);
    compare_events("glitch");
    frame(8'h81, 1'b1, ^8'h81);
    idle(20);
    compare_events("f81");

    // Low stop bit followed by a held-low line
    frame(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    repeat (100) step();
    check("break busy", busy, 1'b0);
    check("break data held", data, 8'h81);
    compare_events("ferr");
    idle(20);
    compare_events("break release");

    // Reset mid-frame at T0+60
    send(8'h5A, 1'b1, ^8'h5A, 63, st);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check_reset_outputs("mid-frame reset");
    @(negedge clock);
    reset = 1'b0;
    last_good = 8'h00;
    idle(2 * NB * BIT);
    compare_events("aborted frame");
    frame(8'hE7, 1'b1, ^8'hE7);
    idle(20);
    compare_events("fE7");
    check("fE7 data", data, 8'hE7);

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b1);
    idle(20);
    compare_events("par good");
    frame(8'h07, 1'b1, 1'b0);
    idle(20);
    compare_events("par bad");
    check("par bad data held", data, 8'h07);
`endif

    // Randomized frames with random gaps and occasional bad stop bits
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(0, 5) != 0);
      rp  = ($urandom_range(0, 3) == 0) ? ~(^rb) : ^rb;
      gap = $urandom_range(0, 12);
      if (!rs && gap == 0) gap = 1;
      frame(rb, rs, rp);
      if (gap > 0) idle(gap);
    end
    idle(20);
    compare_events("random");
    check("random data", data, last_good);
    check("random busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; receive-side counterpart of the start-bit transmitter already on the board.
- Samples the asynchronous `rx` line and reassembles LSB-first bytes.
- Presents each byte on `data` with a one-cycle `valid` strobe.
- Flags malformed frames; sits between a GPIO/UART_RXD pin and consumer logic (7-seg/LED debug, command parser).

Parameters:
- ClockFrequency, 50000000, system clock frequency in Hz.
- BaudRate, 115200, line bit rate in baud.
- BIT (localparam), ClockFrequency/BaudRate (integer division), clocks per bit; elaboration error if BIT < 4.
- HALF (localparam), BIT/2, clocks from start-edge detection to start-bit mid-sample.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- rx  input  1  asynchronous serial line; idle high.
- data  output  8  last correctly received byte.
- valid  output  1  one-cycle strobe; `data` updated in the same cycle.
- frameError  output  1  one-cycle strobe; stop bit sampled low.
- parityError  output  1  one-cycle strobe; parity mismatch (see Optional Feature).
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named `clock` and `reset`.
- Reset values: data=8'h00, valid=0, frameError=0, parityError=0, busy=0, state=IDLE, synchronizer flops=1, prevRx=1.
- Synchronizer: `rx` passes through 2 flops to give `rxSync`. `prevRx` holds `rxSync` from the previous cycle. Total pin-to-`rxSync` latency is 2 edges.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- Down-counter `cnt` with width clog2(BIT). Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- Define T0 as the edge where rxSync==0 and prevRx==1 while in IDLE.
  - IDLE -> START at T0; cnt loads HALF-1.
  - A line that is already low, after reset or after a break, never starts a frame. Only a falling edge arms the receiver.
- Sample edges fall at T0 + HALF + k*BIT, with k=0 for start, k=1..8 for data, k=9 for stop (k=10 for stop when parity is enabled). A sample edge is the edge where cnt==0. cnt reloads BIT-1 at each sample edge.
- START sample:
  - rxSync==0: go to DATA, idx=0.
  - rxSync==1: glitch; return to IDLE silently, no strobe.
- DATA samples: sh = {rxSync, sh[7:1]} (LSB first). After idx==7, go to STOP.
- STOP sample:
  - rxSync==1: data<=sh and valid=1 in the following cycle.
  - rxSync==0: frameError=1 in the following cycle; data unchanged.
  - Either way, go to IDLE.
- Strobes are mutually exclusive and exactly 1 cycle wide.
- A new frame may begin on the first falling edge after returning to IDLE. Back-to-back frames at full rate must be received with no loss.
- Asserting reset mid-frame discards the partial byte; no strobe is issued.
- No flow control. `data` holds until the next valid frame; the consumer must capture it on `valid`.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1.
  - PARITY state follows the 8th data bit and samples at k=9; stop samples at k=10.
  - Expected value is ^sh (even parity).
  - On mismatch, parityError=1 for one cycle in the cycle after the stop sample, and valid is suppressed.
  - If the stop bit is also low, only frameError is raised.
- Not defined: no PARITY state; parityError is tied to 0.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - function clocksPerBit(freq, baud);
  - constant DATA_BITS=8.
  - The package is shared with the transmitter.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect. Reset value 1; outputs rxSync and fall.
- Bit timing stays in uart_rx.

Test Plan (ClockFrequency=16, BaudRate=1 -> BIT=16, HALF=8; timing relative to T0):
- Frame 0x55 (start, 1,0,1,0,1,0,1,0, stop=1) -> valid high for exactly 1 cycle at edge T0+8+144+1, data=8'h55, frameError=0, busy low afterwards.
- Two back-to-back frames 0xA3 then 0x0F, no idle gap -> two valid strobes 160 cycles apart, data=8'hA3 then 8'h0F.
- Start glitch (rx low for 4 cycles, then high) -> no strobe, busy returns to 0 at T0+8, and the next real frame 0x81 is received correctly.
- Frame 0x3C with stop bit low, then line held low for 100 cycles -> frameError 1 cycle, data keeps its previous value, no new frame starts until rx rises then falls.
- Reset pulsed at T0+60 mid-frame -> all outputs return to reset values immediately, no strobe, and the following frame 0xE7 is received.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> valid, data=8'h07; 0x07 with parity bit 0 -> parityError 1 cycle, no valid.
